rej_bounded_sampler: RTL and testbench

Consumes the squeezed SHAKE output vector produced by the `sponge` stage and performs ML-DSA RejBoundedPoly rejection sampling. It turns half-bytes into 256 coefficients bounded by ETA and streams them downstream over a valid/ready interface. It sits directly after the sponge: the sponge's `z`/`done2` pair drives this block's `z_in`/`start`.

---
 rtl/rej_pkg.sv | 28 ++
 rtl/rej_bounded_sampler_coef.sv | 52 +++++
 rtl/rej_bounded_sampler.sv | 194 +++++++++++++++++++
 tb/tb_rej_bounded_sampler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rej_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rej_pkg
//  Description : Shared constants, FSM state type and sizing helper for the
//                ML-DSA RejBoundedPoly sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
package rej_pkg;

  // ML-DSA modulus.
  localparam logic [22:0] Q = 23'd8380417;

  // Default number of coefficients per polynomial.
  localparam int N_DEFAULT = 256;

  typedef enum logic [1:0] {
    REJ_IDLE  = 2'd0,
    REJ_SCAN  = 2'd1,
    REJ_DRAIN = 2'd2
  } rej_state_t;

  // The nibble pointer has to reach 2*D_LEN/8 (one past the last nibble).
  function automatic int ptr_width(input int d_len);
    return $clog2((2 * d_len / 8) + 1);
  endfunction

endpackage : rej_pkg
`default_nettype wire

// File: rtl/rej_bounded_sampler_coef.sv
`default_nettype none
// ============================================================================
//  Module      : coef_from_half_byte
//  Description : Combinational half-byte to bounded coefficient mapping.
//                ETA=2 accepts b<15 and yields 2-(b mod 5); ETA=4 accepts
//                b<9 and yields 4-b. Any other ETA fails elaboration.
//                Output encoding is selected by REJ_COEF_MODQ_EN:
//                defined   -> value mod Q (negative v emitted as Q+v)
//                undefined -> 23-bit two's complement
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_from_half_byte
  import rej_pkg::*;
#(
  parameter int ETA = 2
) (
  input  logic [3:0]  nib_i,
  output logic        accept_o,
  output logic [22:0] value_o
);

  // Narrow signed result; range is +4..-11 across both ETA settings.
  logic signed [4:0] w_val;
  logic [22:0]       w_sext;

  generate
    if (ETA == 2) begin : g_eta2
      logic [3:0] w_mod5;
      assign w_mod5   = nib_i % 4'd5;
      assign accept_o = (nib_i < 4'd15);
      assign w_val    = 5'sd2 - $signed({1'b0, w_mod5});
    end else if (ETA == 4) begin : g_eta4
      assign accept_o = (nib_i < 4'd9);
      assign w_val    = 5'sd4 - $signed({1'b0, nib_i});
    end else begin : g_eta_bad
      $error("coef_from_half_byte: ETA must be 2 or 4");
      assign accept_o = 1'b0;
      assign w_val    = '0;
    end
  endgenerate

  assign w_sext = {{18{w_val[4]}}, w_val};

`ifdef REJ_COEF_MODQ_EN
  // Adding Q modulo 2^23 to the sign-extended value maps v<0 onto Q+v.
  assign value_o = w_val[4] ? (w_sext + Q) : w_sext;
`else
  assign value_o = w_sext;
`endif

endmodule : coef_from_half_byte
`default_nettype wire

// File: rtl/rej_bounded_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : rej_bounded_sampler
//  Description : ML-DSA RejBoundedPoly rejection sampler. Captures the
//                squeezed SHAKE vector on start, scans one nibble per cycle
//                (low nibble of each byte first) and streams N bounded
//                coefficients over a valid/ready interface. Flags starved
//                when the input runs out before N coefficients.
//                Optional macro REJ_COEF_MODQ_EN selects mod-Q output
//                encoding instead of 23-bit two's complement.
//  Revision    : 1.0 - initial release
// ============================================================================
module rej_bounded_sampler
  import rej_pkg::*;
#(
  parameter int D_LEN = 4096,
  parameter int ETA   = 2,
  parameter int N     = N_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [D_LEN-1:0] z_in,
  output logic [22:0]      coef_o,
  output logic [7:0]       coef_idx,
  output logic             coef_valid,
  input  logic             coef_ready,
  output logic             busy,
  output logic             done,
  output logic             starved
);

  localparam int NIB_CNT = 2 * D_LEN / 8;
  localparam int PTR_W   = ptr_width(D_LEN);
  localparam int CNT_W   = $clog2(N + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NIB_CNT - 1);
  localparam logic [CNT_W-1:0] N_C      = CNT_W'(N);

  generate
    if ((D_LEN % 8) != 0 || D_LEN <= 0) begin : g_dlen_bad
      $error("rej_bounded_sampler: D_LEN must be a positive multiple of 8");
    end
    if (N < 1 || N > 256) begin : g_n_bad
      $error("rej_bounded_sampler: N must be in 1..256");
    end
  endgenerate

  rej_state_t       state_q, state_d;
  logic [D_LEN-1:0] buf_q;
  logic             load_buf;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [22:0]      coef_q, coef_d;
  logic [7:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             starved_q, starved_d;

  logic [PTR_W+1:0] nib_bit;
  logic [3:0]       nib;
  logic             nib_accept;
  logic [22:0]      nib_value;
  logic             hs;
  logic             slot_free;

  // Nibble k occupies bits 4k+3:4k, which gives low-then-high order per byte.
  assign nib_bit   = {ptr_q, 2'b00};
  assign nib       = buf_q[nib_bit +: 4];
  assign hs        = valid_q && coef_ready;
  assign slot_free = !valid_q || coef_ready;
  assign cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  coef_from_half_byte #(
    .ETA (ETA)
  ) u_coef (
    .nib_i    (nib),
    .accept_o (nib_accept),
    .value_o  (nib_value)
  );

  // Input buffer: cleared on reset, loaded only when a run starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q <= '0;
    end else if (load_buf) begin
      buf_q <= z_in;
    end
  end

  // State, pointer, count and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= REJ_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      coef_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      coef_q    <= coef_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      starved_q <= starved_d;
    end
  end

  // Next-state logic: scan one nibble per free output slot, finish on the
  // Nth handshake or when the input is exhausted.
  always_comb begin
    state_d   = state_q;
    load_buf  = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    coef_d    = coef_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    starved_d = starved_q;

    unique case (state_q)
      REJ_IDLE: begin
        if (start) begin
          load_buf  = 1'b1;
          ptr_d     = '0;
          cnt_d     = '0;
          valid_d   = 1'b0;
          starved_d = 1'b0;
          state_d   = REJ_SCAN;
        end
      end

      REJ_SCAN: begin
        if (hs) begin
          cnt_d   = cnt_inc;
          valid_d = 1'b0;
        end
        if (hs && (cnt_inc == N_C)) begin
          done_d  = 1'b1;
          state_d = REJ_IDLE;
        end else if (slot_free) begin
          ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
          if (nib_accept) begin
            coef_d  = nib_value;
            idx_d   = 8'(cnt_d);
            valid_d = 1'b1;
          end
          // Last nibble consumed: finish now unless a coefficient is pending.
          if (ptr_q == LAST_PTR) begin
            if (nib_accept) begin
              state_d = REJ_DRAIN;
            end else begin
              done_d    = 1'b1;
              starved_d = 1'b1;
              state_d   = REJ_IDLE;
            end
          end
        end
      end

      REJ_DRAIN: begin
        if (slot_free) begin
          valid_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = REJ_IDLE;
          starved_d = 1'b1;
          if (hs) begin
            cnt_d     = cnt_inc;
            starved_d = (cnt_inc != N_C);
          end
        end
      end

      default: begin
        state_d = REJ_IDLE;
      end
    endcase
  end

  assign coef_o     = coef_q;
  assign coef_idx   = idx_q;
  assign coef_valid = valid_q;
  assign busy       = (state_q != REJ_IDLE);
  assign done       = done_q;
  assign starved    = starved_q;

endmodule : rej_bounded_sampler
`default_nettype wire

// File: tb/tb_rej_bounded_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rej_bounded_sampler
//  Description : Directed self-checking bench for rej_bounded_sampler with an
//                ETA=2 and an ETA=4 instance sharing the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rej_bounded_sampler;

`ifdef REJ_COEF_MODQ_EN
  localparam logic [22:0] C_M2 = 23'd8380415;
  localparam logic [22:0] C_M1 = 23'd8380416;
`else
  localparam logic [22:0] C_M2 = 23'h7FFFFE;
  localparam logic [22:0] C_M1 = 23'h7FFFFF;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          coef_ready = 1'b0;
  logic [4095:0] z_in = '0;

  logic [22:0] c2_coef, c4_coef;
  logic [7:0]  c2_idx, c4_idx;
  logic        c2_valid, c4_valid, c2_busy, c4_busy;
  logic        c2_done, c4_done, c2_starved, c4_starved;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rej_bounded_sampler #(.D_LEN(4096), .ETA(2), .N(256)) dut2 (
    .clk(clk), .reset(reset), .start(start), .z_in(z_in),
    .coef_o(c2_coef), .coef_idx(c2_idx), .coef_valid(c2_valid),
    .coef_ready(coef_ready), .busy(c2_busy), .done(c2_done),
    .starved(c2_starved)
  );

  rej_bounded_sampler #(.D_LEN(4096), .ETA(4), .N(256)) dut4 (
    .clk(clk), .reset(reset), .start(start), .z_in(z_in),
    .coef_o(c4_coef), .coef_idx(c4_idx), .coef_valid(c4_valid),
    .coef_ready(coef_ready), .busy(c4_busy), .done(c4_done),
    .starved(c4_starved)
  );

  // Drive start for one cycle; returns at the negedge of cycle 1.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({c2_coef, c2_idx, c2_valid, c2_busy, c2_done, c2_starved} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_eta2: got coef=%0h idx=%0d v=%b busy=%b done=%b st=%b, want all 0",
               c2_coef, c2_idx, c2_valid, c2_busy, c2_done, c2_starved);
    end
    n_checks++;
    if ({c4_coef, c4_idx, c4_valid, c4_busy, c4_done, c4_starved} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_eta4: got coef=%0h idx=%0d v=%b busy=%b done=%b st=%b, want all 0",
               c4_coef, c4_idx, c4_valid, c4_busy, c4_done, c4_starved);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_coefs();
    z_in = '0; coef_ready = 1'b1;
    pulse_start();
    n_checks++;
    if (c2_valid !== 1'b0 || c2_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_cycle1: valid=%b busy=%b, want valid=0 busy=1", c2_valid, c2_busy);
    end
    @(negedge clk);
    n_checks++;
    if (c2_valid !== 1'b1 || c2_coef !== 23'd2 || c2_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL first_coef0: valid=%b coef=%0d idx=%0d, want 1/2/0", c2_valid, c2_coef, c2_idx);
    end
    n_checks++;
    if (c4_valid !== 1'b1 || c4_coef !== 23'd4 || c4_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL first_eta4_coef0: valid=%b coef=%0d idx=%0d, want 1/4/0", c4_valid, c4_coef, c4_idx);
    end
    @(negedge clk);
    n_checks++;
    if (c2_valid !== 1'b1 || c2_coef !== 23'd2 || c2_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL first_coef1: valid=%b coef=%0d idx=%0d, want 1/2/1", c2_valid, c2_coef, c2_idx);
    end
    do_reset();
  endtask

  task automatic test_neg_values();
    z_in = '0; z_in[7:0] = 8'h3E; coef_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (c2_valid !== 1'b1 || c2_coef !== C_M2 || c2_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL neg_m2: valid=%b coef=%0h idx=%0d, want 1/%0h/0", c2_valid, c2_coef, c2_idx, C_M2);
    end
    n_checks++;
    if (c4_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_eta4_reject14: valid=%b, want 0", c4_valid);
    end
    @(negedge clk);
    n_checks++;
    if (c2_valid !== 1'b1 || c2_coef !== C_M1 || c2_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL neg_m1: valid=%b coef=%0h idx=%0d, want 1/%0h/1", c2_valid, c2_coef, c2_idx, C_M1);
    end
    n_checks++;
    if (c4_valid !== 1'b1 || c4_coef !== 23'd1 || c4_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL neg_eta4_nib3: valid=%b coef=%0d idx=%0d, want 1/1/0", c4_valid, c4_coef, c4_idx);
    end
    do_reset();
  endtask

  task automatic test_eta4_reject();
    z_in = '0; z_in[7:0] = 8'h9A; z_in[15:8] = 8'h21; coef_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (c2_valid !== 1'b1 || c2_coef !== 23'd2) begin
      n_fail++;
      $display("FAIL eta2_nib10: valid=%b coef=%0d, want 1/2", c2_valid, c2_coef);
    end
    n_checks++;
    if (c4_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL eta4_rej_A: valid=%b, want 0", c4_valid);
    end
    @(negedge clk);
    n_checks++;
    if (c4_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL eta4_rej_9: valid=%b, want 0", c4_valid);
    end
    @(negedge clk);
    n_checks++;
    if (c4_valid !== 1'b1 || c4_coef !== 23'd3 || c4_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL eta4_byte1_lo: valid=%b coef=%0d idx=%0d, want 1/3/0", c4_valid, c4_coef, c4_idx);
    end
    @(negedge clk);
    n_checks++;
    if (c4_valid !== 1'b1 || c4_coef !== 23'd2 || c4_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL eta4_byte1_hi: valid=%b coef=%0d idx=%0d, want 1/2/1", c4_valid, c4_coef, c4_idx);
    end
    do_reset();
  endtask

  task automatic test_starved();
    int cyc;
    bit saw_valid;
    z_in = '1; coef_ready = 1'b1;
    pulse_start();
    cyc = 1; saw_valid = 1'b0;
    while (!c2_done && cyc < 2000) begin
      if (c2_valid || c4_valid) saw_valid = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (c2_done !== 1'b1 || cyc !== 1025) begin
      n_fail++;
      $display("FAIL starved_done_cycle: done=%b at cycle %0d, want done=1 at cycle 1025", c2_done, cyc);
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL starved_no_valid: saw_valid=%b, want 0", saw_valid);
    end
    n_checks++;
    if (c2_starved !== 1'b1 || c2_busy !== 1'b0 || c4_done !== 1'b1 || c4_starved !== 1'b1) begin
      n_fail++;
      $display("FAIL starved_flags: st2=%b busy2=%b done4=%b st4=%b, want 1/0/1/1",
               c2_starved, c2_busy, c4_done, c4_starved);
    end
    @(negedge clk);
    n_checks++;
    if (c2_done !== 1'b0 || c2_starved !== 1'b1) begin
      n_fail++;
      $display("FAIL starved_level: done=%b starved=%b, want 0/1", c2_done, c2_starved);
    end
  endtask

  task automatic test_full_run_stall();
    int cyc;
    int hs_cnt;
    bit stalled;
    logic [22:0] p_coef;
    logic [7:0]  p_idx;
    z_in = '0; coef_ready = 1'b1;
    pulse_start();
    n_checks++;
    if (c2_starved !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears_starved: starved=%b, want 0", c2_starved);
    end
    cyc = 1; hs_cnt = 0; stalled = 1'b0; p_coef = '0; p_idx = '0;
    while (hs_cnt < 256 && cyc < 4000) begin
      if (stalled) begin
        n_checks++;
        if (c2_valid !== 1'b1 || c2_coef !== p_coef || c2_idx !== p_idx) begin
          n_fail++;
          $display("FAIL stall_stable: valid=%b coef=%0d idx=%0d, want 1/%0d/%0d",
                   c2_valid, c2_coef, c2_idx, p_coef, p_idx);
        end
      end
      if (c2_done !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL early_done: done=%b after %0d handshakes, want 0", c2_done, hs_cnt);
      end
      coef_ready = ~coef_ready;
      if (c2_valid && coef_ready) begin
        n_checks++;
        if (c2_idx !== 8'(hs_cnt) || c2_coef !== 23'd2 || c4_coef !== 23'd4 || c4_idx !== 8'(hs_cnt)) begin
          n_fail++;
          $display("FAIL hs_value: idx2=%0d coef2=%0d idx4=%0d coef4=%0d, want idx %0d coef 2/4",
                   c2_idx, c2_coef, c4_idx, c4_coef, hs_cnt);
        end
        hs_cnt++;
      end
      stalled = c2_valid && !coef_ready;
      p_coef  = c2_coef;
      p_idx   = c2_idx;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (hs_cnt !== 256) begin
      n_fail++;
      $display("FAIL full_hs_count: got %0d handshakes, want 256", hs_cnt);
    end
    n_checks++;
    if (c2_done !== 1'b1 || c2_starved !== 1'b0 || c2_busy !== 1'b0 || c2_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: done=%b starved=%b busy=%b valid=%b, want 1/0/0/0",
               c2_done, c2_starved, c2_busy, c2_valid);
    end
    n_checks++;
    if (c4_done !== 1'b1 || c4_starved !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_eta4: done=%b starved=%b, want 1/0", c4_done, c4_starved);
    end
    @(negedge clk);
    n_checks++;
    if (c2_done !== 1'b0 || c2_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_pulse: done=%b valid=%b, want 0/0", c2_done, c2_valid);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    z_in = '0; coef_ready = 1'b1;
    pulse_start();
    cyc = 1;
    while (!(c2_valid && c2_idx == 8'd100) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (c2_valid !== 1'b1 || c2_idx !== 8'd100) begin
      n_fail++;
      $display("FAIL midrun_reach100: valid=%b idx=%0d, want 1/100", c2_valid, c2_idx);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({c2_coef, c2_idx, c2_valid, c2_busy, c2_done, c2_starved} !== 35'd0) begin
      n_fail++;
      $display("FAIL midrun_async_clear: coef=%0d idx=%0d v=%b busy=%b done=%b st=%b, want all 0",
               c2_coef, c2_idx, c2_valid, c2_busy, c2_done, c2_starved);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (c2_done !== 1'b0 || c2_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_no_done: done=%b busy=%b, want 0/0", c2_done, c2_busy);
      end
    end
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (c2_valid !== 1'b1 || c2_idx !== 8'd0 || c2_coef !== 23'd2) begin
      n_fail++;
      $display("FAIL midrun_restart: valid=%b idx=%0d coef=%0d, want 1/0/2", c2_valid, c2_idx, c2_coef);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_first_coefs();
    test_neg_values();
    test_eta4_reject();
    test_starved();
    test_full_run_stall();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rej_bounded_sampler
`default_nettype wire
